accumulator_control_unit: RTL and testbench
===========================================

Name: accumulator_control_unit

Overview:
Multi-cycle FSM controller for the 11-bit accumulator datapath. Holds the program counter (PC) and instruction register (IR), and fetches 16-bit instructions (5-bit opcode, 11-bit operand) from a synchronous instruction memory. Decodes each opcode into the datapath's select, write, reset and ALU controls plus the data-memory write strobe. Evaluates conditional branches against the datapath's registered Z/N flags.

Parameters:
DATA_WIDTH, 11, operand/datapath width; also PC width.
OPCODE_WIDTH, 5, opcode field width; instruction width = OPCODE_WIDTH + DATA_WIDTH.

Ports:
clock_in  input  1  system clock, rising edge
reset_in  input  1  synchronous, active-high reset
instr_in  input  OPCODE_WIDTH+DATA_WIDTH  instruction memory read data, valid 1 cycle after instr_addr_out
flag_Z_in  input  1  datapath zero flag
flag_N_in  input  1  datapath negative flag
instr_addr_out  output  DATA_WIDTH  instruction address (= PC)
operand_out  output  DATA_WIDTH  IR[DATA_WIDTH-1:0]; drives datapath operand_in
alu_op_out  output  1  0=add, 1=sub
sel_A_out  output  2  00 data memory, 01 ext, 10 ALU
sel_B_out  output  1  1 ext, 0 data memory
acc_wr_out  output  1  accumulator write
status_wr_out  output  1  flag register write
acc_reset_out  output  1  accumulator clear
status_reset_out  output  1  flag clear
data_mem_wr_out  output  1  data memory write (data = accumulator)
halted_out  output  1  high in HALTED state
illegal_out  output  1  sticky illegal-opcode indicator (see Optional Feature)

Behaviour:
- Clock/reset: one clock, clock_in. reset_in is synchronous and active-high. While reset_in=1 at an edge: state<=INIT, PC<=0, IR<=0.
- Reset values: all outputs 0 (sel_A_out=00, operand_out=0, instr_addr_out=0). Reset mid-instruction aborts the instruction; no write strobe is asserted in any cycle where reset_in=1.
- States: INIT, FETCH, DECODE, EXEC, WB, HALTED.
- INIT: acc_reset_out=1, status_reset_out=1. Next state FETCH.
- FETCH: instr_addr_out=PC. Next state DECODE.
- DECODE: IR<=instr_in; PC<=PC+1. PC wraps 2^DATA_WIDTH-1 -> 0. Next state EXEC.
- EXEC/WB per opcode. All unlisted controls are 0.
  - 0 HLT: next HALTED.
  - 1 STO: data_mem_wr_out=1. Next FETCH.
  - 2 LD: EXEC waits for memory read, then WB: sel_A=00, acc_wr=1. Next FETCH.
  - 3 LDI: sel_A=01, acc_wr=1. Next FETCH.
  - 4 ADD: EXEC waits, then WB: sel_B=0, alu_op=0, sel_A=10, acc_wr=1, status_wr=1.
  - 5 ADDI: in EXEC: sel_B=1, alu_op=0, sel_A=10, acc_wr=1, status_wr=1.
  - 6 SUB: as ADD with alu_op=1.
  - 7 SUBI: as ADDI with alu_op=1.
  - 8 BEQ: taken if Z.
  - 9 BNE: taken if !Z.
  - 10 BGT: taken if !N & !Z.
  - 11 BGE: taken if !N.
  - 12 BLT: taken if N.
  - 13 BLE: taken if N | Z.
  - 14 JMP: always taken.
- Branches: if taken, PC<=operand in EXEC; otherwise PC unchanged. Flags are sampled in EXEC and reflect the last completed ALU instruction. LD/LDI do not update flags.
- Opcodes 15-31 are illegal: behave as NOP (EXEC -> FETCH) unless the Optional Feature is enabled.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXEC) for immediate, store, branch and halt. 4 cycles for LD/ADD/SUB (adds WB).
- Branch to a target equal to the branch's own address is legal and loops forever.
- HALTED: all strobes 0, halted_out=1. PC and IR hold. Exit only via reset_in.

Optional Feature:
Macro ILLEGAL_OP_HALT_EN.
- Defined: an illegal opcode in EXEC sets illegal_out=1 and goes to HALTED. illegal_out stays 1 until reset.
- Undefined: an illegal opcode executes as a NOP; illegal_out is tied to 0.

Test Plan:
- Reset held 2 cycles, then released -> INIT cycle shows acc_reset_out=1 and status_reset_out=1; instr_addr_out=0 in the following FETCH; all strobes 0 during reset.
- Program LDI 5; ADDI 3; STO 20; HLT -> acc_wr pulses in cycles 3 and 6 after the first FETCH; data_mem_wr_out=1 with operand_out=20 in the STO EXEC; halted_out=1 after the 4th instruction.
- LD 7 with mem[7]=9 -> acc_wr_out=1 only in WB (4th cycle), sel_A_out=00; ADD 7 gives sel_B_out=0, sel_A_out=10, status_wr_out=1 in WB.
- SUBI 4 on acc=4 (Z=1), then BEQ 100 -> next instr_addr_out=100. Repeat with acc=5 -> next instr_addr_out = branch address + 1. Cover BLT taken with N=1 and BGT not taken with Z=1.
- PC=2047 executing LDI -> next fetch address 0. Assert reset_in during a WB cycle -> acc_wr_out=0 that cycle, PC=0 afterwards.
- Opcode 20 -> with ILLEGAL_OP_HALT_EN: illegal_out=1, halted_out=1; without: next FETCH at PC+1 and illegal_out=0.

Source files
------------

// File: rtl/accumulator_control_unit_if.sv
// Control/status bundle between the accumulator control unit (master) and
// its instruction memory and datapath (slave).
interface accumulator_control_unit_if #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
);
  logic [OPCODE_WIDTH+DATA_WIDTH-1:0] instr_in;
  logic                               flag_Z_in;
  logic                               flag_N_in;
  logic [DATA_WIDTH-1:0]              instr_addr_out;
  logic [DATA_WIDTH-1:0]              operand_out;
  logic                               alu_op_out;
  logic [1:0]                         sel_A_out;
  logic                               sel_B_out;
  logic                               acc_wr_out;
  logic                               status_wr_out;
  logic                               acc_reset_out;
  logic                               status_reset_out;
  logic                               data_mem_wr_out;
  logic                               halted_out;
  logic                               illegal_out;

  modport master (
    input  instr_in, flag_Z_in, flag_N_in,
    output instr_addr_out, operand_out, alu_op_out, sel_A_out, sel_B_out,
           acc_wr_out, status_wr_out, acc_reset_out, status_reset_out,
           data_mem_wr_out, halted_out, illegal_out
  );

  modport slave (
    output instr_in, flag_Z_in, flag_N_in,
    input  instr_addr_out, operand_out, alu_op_out, sel_A_out, sel_B_out,
           acc_wr_out, status_wr_out, acc_reset_out, status_reset_out,
           data_mem_wr_out, halted_out, illegal_out
  );
endinterface

// File: rtl/accumulator_control_unit.sv
// Multi-cycle FSM controller (PC, IR, decode, branch) for the accumulator datapath.
// Optional macro ILLEGAL_OP_HALT_EN: illegal opcodes halt and set a sticky illegal flag.
module accumulator_control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 5
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  accumulator_control_unit_if.master  bus
);
  localparam int INSTR_WIDTH = OPCODE_WIDTH + DATA_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
  localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_EXT = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, WB, HALTED} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   pc, pc_next;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   operand;
  logic                    taken;
  logic                    illegal;

  logic                    alu_op, sel_b, acc_wr, status_wr;
  logic                    acc_reset, status_reset, data_mem_wr, halted;
  logic [1:0]              sel_a;

  assign opcode  = ir[INSTR_WIDTH-1:DATA_WIDTH];
  assign operand = ir[DATA_WIDTH-1:0];

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state <= INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == DECODE) begin
        ir <= bus.instr_in;
      end
    end
  end

`ifdef ILLEGAL_OP_HALT_EN
  logic is_illegal;
  assign is_illegal = (opcode > OP_JMP);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      illegal <= 1'b0;
    end else if (state == EXEC && is_illegal) begin
      illegal <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
`endif

  // Flags are registered in the datapath, so they already reflect the last ALU op.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = bus.flag_Z_in;
      OP_BNE:  taken = !bus.flag_Z_in;
      OP_BGT:  taken = !bus.flag_N_in && !bus.flag_Z_in;
      OP_BGE:  taken = !bus.flag_N_in;
      OP_BLT:  taken = bus.flag_N_in;
      OP_BLE:  taken = bus.flag_N_in || bus.flag_Z_in;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    alu_op       = 1'b0;
    sel_a        = SEL_A_MEM;
    sel_b        = 1'b0;
    acc_wr       = 1'b0;
    status_wr    = 1'b0;
    acc_reset    = 1'b0;
    status_reset = 1'b0;
    data_mem_wr  = 1'b0;
    halted       = 1'b0;
    case (state)
      INIT: begin
        acc_reset    = 1'b1;
        status_reset = 1'b1;
        state_next   = FETCH;
      end
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        pc_next    = pc + 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        case (opcode)
          OP_HLT: state_next = HALTED;
          OP_STO: data_mem_wr = 1'b1;
          OP_LD, OP_ADD, OP_SUB: state_next = WB;
          OP_LDI: begin
            sel_a  = SEL_A_EXT;
            acc_wr = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            sel_b     = 1'b1;
            alu_op    = (opcode == OP_SUBI);
            sel_a     = SEL_A_ALU;
            acc_wr    = 1'b1;
            status_wr = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
            if (taken) begin
              pc_next = operand;
            end
          end
          default: begin
`ifdef ILLEGAL_OP_HALT_EN
            state_next = HALTED;
`endif
          end
        endcase
      end
      // Memory-sourced operands arrive one cycle after EXEC presents the address.
      WB: begin
        state_next = FETCH;
        case (opcode)
          OP_LD: begin
            sel_a  = SEL_A_MEM;
            acc_wr = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_b     = 1'b0;
            alu_op    = (opcode == OP_SUB);
            sel_a     = SEL_A_ALU;
            acc_wr    = 1'b1;
            status_wr = 1'b1;
          end
          default: ;
        endcase
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Reset masks every output so an aborted instruction cannot strobe a write.
  always_comb begin
    bus.instr_addr_out   = pc;
    bus.operand_out      = operand;
    bus.alu_op_out       = alu_op;
    bus.sel_A_out        = sel_a;
    bus.sel_B_out        = sel_b;
    bus.acc_wr_out       = acc_wr;
    bus.status_wr_out    = status_wr;
    bus.acc_reset_out    = acc_reset;
    bus.status_reset_out = status_reset;
    bus.data_mem_wr_out  = data_mem_wr;
    bus.halted_out       = halted;
    bus.illegal_out      = illegal;
    if (reset_in) begin
      bus.instr_addr_out   = '0;
      bus.operand_out      = '0;
      bus.alu_op_out       = 1'b0;
      bus.sel_A_out        = 2'b00;
      bus.sel_B_out        = 1'b0;
      bus.acc_wr_out       = 1'b0;
      bus.status_wr_out    = 1'b0;
      bus.acc_reset_out    = 1'b0;
      bus.status_reset_out = 1'b0;
      bus.data_mem_wr_out  = 1'b0;
      bus.halted_out       = 1'b0;
      bus.illegal_out      = 1'b0;
    end
  end
endmodule

// File: tb/tb_accumulator_control_unit.sv
// Scoreboard bench for accumulator_control_unit: directed programs push per-cycle
// expectations; a negedge monitor pops and compares them.
module tb_accumulator_control_unit;
  logic clock_in;
  logic reset_in;
  int   cyc;
  int   checks;
  int   failures;

  accumulator_control_unit_if #(.DATA_WIDTH(11), .OPCODE_WIDTH(5)) bus ();

  accumulator_control_unit #(.DATA_WIDTH(11), .OPCODE_WIDTH(5)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  localparam logic [4:0] HLT = 5'd0,  STO = 5'd1,  LD  = 5'd2,  LDI  = 5'd3;
  localparam logic [4:0] ADD = 5'd4,  ADDI = 5'd5, SUB = 5'd6,  SUBI = 5'd7;
  localparam logic [4:0] BEQ = 5'd8,  BNE = 5'd9,  BGT = 5'd10, BGE  = 5'd11;
  localparam logic [4:0] BLT = 5'd12, BLE = 5'd13, JMP = 5'd14, BAD  = 5'd20;

  // ctrl = {alu_op, sel_A[1:0], sel_B, acc_wr, status_wr, acc_reset, status_reset, dmem_wr, halted, illegal}
  localparam logic [10:0] C_NONE    = 11'b0_00_0_0_0_0_0_0_0_0;
  localparam logic [10:0] C_INIT    = 11'b0_00_0_0_0_1_1_0_0_0;
  localparam logic [10:0] C_LDI     = 11'b0_01_0_1_0_0_0_0_0_0;
  localparam logic [10:0] C_ADDI    = 11'b0_10_1_1_1_0_0_0_0_0;
  localparam logic [10:0] C_SUBI    = 11'b1_10_1_1_1_0_0_0_0_0;
  localparam logic [10:0] C_STO     = 11'b0_00_0_0_0_0_0_1_0_0;
  localparam logic [10:0] C_LDWB    = 11'b0_00_0_1_0_0_0_0_0_0;
  localparam logic [10:0] C_ADDWB   = 11'b0_10_0_1_1_0_0_0_0_0;
  localparam logic [10:0] C_SUBWB   = 11'b1_10_0_1_1_0_0_0_0_0;
  localparam logic [10:0] C_HALT    = 11'b0_00_0_0_0_0_0_0_1_0;
  localparam logic [10:0] C_HALTILL = 11'b0_00_0_0_0_0_0_0_1_1;

  typedef struct {
    int          cyc;
    string       name;
    logic [10:0] addr;
    logic [10:0] opnd;
    logic [10:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] imem [2048];
  logic [10:0] got_ctrl;

  assign got_ctrl = {bus.alu_op_out, bus.sel_A_out, bus.sel_B_out, bus.acc_wr_out,
                     bus.status_wr_out, bus.acc_reset_out, bus.status_reset_out,
                     bus.data_mem_wr_out, bus.halted_out, bus.illegal_out};

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  initial cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  // Synchronous instruction memory: data valid one cycle after the address.
  always @(posedge clock_in) bus.instr_in <= imem[bus.instr_addr_out];

  // Monitor: every expectation due at or before this cycle is popped and compared.
  always @(negedge clock_in) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || bus.instr_addr_out !== e.addr || bus.operand_out !== e.opnd ||
          got_ctrl !== e.ctrl) begin
        failures++;
        $display("[TB] FAIL %s @cyc %0d (due %0d): got addr=%0d opnd=%0d ctrl=%b, want addr=%0d opnd=%0d ctrl=%b",
                 e.name, cyc, e.cyc, bus.instr_addr_out, bus.operand_out, got_ctrl,
                 e.addr, e.opnd, e.ctrl);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] ins(input logic [4:0] op, input int opnd);
    return {op, 11'(opnd)};
  endfunction

  task automatic push_exp(input int c, input string n, input int a, input int o,
                          input logic [10:0] ctrl);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.addr = 11'(a);
    e.opnd = 11'(o);
    e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) imem[i] = ins(HLT, 0);
  endtask

  // Two reset cycles then INIT; returns the cycle of the first FETCH.
  task automatic start_run(input logic z, input logic n, output int f);
    int b;
    bus.flag_Z_in = z;
    bus.flag_N_in = n;
    tick(1);
    reset_in = 1'b1;
    b = cyc;
    push_exp(b,     "reset0", 0, 0, C_NONE);
    push_exp(b + 1, "reset1", 0, 0, C_NONE);
    tick(2);
    reset_in = 1'b0;
    push_exp(b + 2, "init", 0, 0, C_INIT);
    f = b + 3;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock_in);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_%s: pending=%0d, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int f;
    checks   = 0;
    failures = 0;
    reset_in = 1'b1;
    bus.flag_Z_in = 1'b0;
    bus.flag_N_in = 1'b0;

    // LDI 5; ADDI 3; STO 20; HLT
    clear_mem();
    imem[0] = ins(LDI, 5); imem[1] = ins(ADDI, 3); imem[2] = ins(STO, 20); imem[3] = ins(HLT, 0);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 0,  "p1_fetch0", 0, 0, C_NONE);
    push_exp(f + 1,  "p1_dec0",   0, 0, C_NONE);
    push_exp(f + 2,  "p1_ldi",    1, 5, C_LDI);
    push_exp(f + 3,  "p1_fetch1", 1, 5, C_NONE);
    push_exp(f + 4,  "p1_dec1",   1, 5, C_NONE);
    push_exp(f + 5,  "p1_addi",   2, 3, C_ADDI);
    push_exp(f + 6,  "p1_fetch2", 2, 3, C_NONE);
    push_exp(f + 8,  "p1_sto",    3, 20, C_STO);
    push_exp(f + 9,  "p1_fetch3", 3, 20, C_NONE);
    push_exp(f + 11, "p1_hlt",    4, 0, C_NONE);
    push_exp(f + 12, "p1_halt0",  4, 0, C_HALT);
    push_exp(f + 13, "p1_halt1",  4, 0, C_HALT);
    wait_drain("p1");

    // LD 7; ADD 7; SUB 2; HLT
    clear_mem();
    imem[0] = ins(LD, 7); imem[1] = ins(ADD, 7); imem[2] = ins(SUB, 2); imem[3] = ins(HLT, 0);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 2,  "p2_ld_exec",  1, 7, C_NONE);
    push_exp(f + 3,  "p2_ld_wb",    1, 7, C_LDWB);
    push_exp(f + 4,  "p2_fetch1",   1, 7, C_NONE);
    push_exp(f + 6,  "p2_add_exec", 2, 7, C_NONE);
    push_exp(f + 7,  "p2_add_wb",   2, 7, C_ADDWB);
    push_exp(f + 8,  "p2_fetch2",   2, 7, C_NONE);
    push_exp(f + 10, "p2_sub_exec", 3, 2, C_NONE);
    push_exp(f + 11, "p2_sub_wb",   3, 2, C_SUBWB);
    push_exp(f + 14, "p2_hlt",      4, 0, C_NONE);
    push_exp(f + 15, "p2_halt",     4, 0, C_HALT);
    wait_drain("p2");

    // Z=1: BEQ taken, BGT not taken
    clear_mem();
    imem[0] = ins(SUBI, 4); imem[1] = ins(BEQ, 100); imem[100] = ins(BGT, 300); imem[101] = ins(HLT, 0);
    start_run(1'b1, 1'b0, f);
    push_exp(f + 2,  "p3a_subi",    1, 4, C_SUBI);
    push_exp(f + 5,  "p3a_beq",     2, 100, C_NONE);
    push_exp(f + 6,  "p3a_fetch",   100, 100, C_NONE);
    push_exp(f + 8,  "p3a_bgt",     101, 300, C_NONE);
    push_exp(f + 9,  "p3a_fetch2",  101, 300, C_NONE);
    push_exp(f + 12, "p3a_halt",    102, 0, C_HALT);
    wait_drain("p3a");

    // Z=0,N=0: BEQ not taken, BGT taken
    clear_mem();
    imem[0] = ins(SUBI, 4); imem[1] = ins(BEQ, 100); imem[2] = ins(BGT, 9); imem[9] = ins(HLT, 0);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 2,  "p3b_subi",   1, 4, C_SUBI);
    push_exp(f + 6,  "p3b_fetch",  2, 100, C_NONE);
    push_exp(f + 9,  "p3b_fetch2", 9, 9, C_NONE);
    push_exp(f + 12, "p3b_halt",   10, 0, C_HALT);
    wait_drain("p3b");

    // N=1,Z=0: BLT/BLE/BNE taken, BGE/BEQ/BGT not taken, JMP self-loop
    clear_mem();
    imem[0]  = ins(BLT, 50); imem[50] = ins(BLE, 60); imem[60] = ins(BNE, 70);
    imem[70] = ins(BGE, 80); imem[71] = ins(BEQ, 90); imem[72] = ins(BGT, 90); imem[73] = ins(JMP, 73);
    start_run(1'b0, 1'b1, f);
    push_exp(f + 3,  "p3c_blt", 50, 50, C_NONE);
    push_exp(f + 6,  "p3c_ble", 60, 60, C_NONE);
    push_exp(f + 9,  "p3c_bne", 70, 70, C_NONE);
    push_exp(f + 12, "p3c_bge", 71, 80, C_NONE);
    push_exp(f + 15, "p3c_beq", 72, 90, C_NONE);
    push_exp(f + 18, "p3c_bgt", 73, 90, C_NONE);
    push_exp(f + 21, "p3c_jmp", 73, 73, C_NONE);
    push_exp(f + 24, "p3c_loop", 73, 73, C_NONE);
    wait_drain("p3c");

    // Z=1,N=0: BNE not taken, BLE/BGE taken, BLT not taken
    clear_mem();
    imem[0] = ins(BNE, 40); imem[1] = ins(BLE, 40); imem[40] = ins(BGE, 45); imem[45] = ins(BLT, 10);
    start_run(1'b1, 1'b0, f);
    push_exp(f + 3,  "p3d_bne", 1, 40, C_NONE);
    push_exp(f + 6,  "p3d_ble", 40, 40, C_NONE);
    push_exp(f + 9,  "p3d_bge", 45, 45, C_NONE);
    push_exp(f + 12, "p3d_blt", 46, 10, C_NONE);
    push_exp(f + 15, "p3d_halt", 47, 0, C_HALT);
    wait_drain("p3d");

    // Illegal opcode 20
    clear_mem();
    imem[0] = ins(BAD, 5); imem[1] = ins(HLT, 0);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 2, "p5_exec", 1, 5, C_NONE);
`ifdef ILLEGAL_OP_HALT_EN
    push_exp(f + 3, "p5_halt0", 1, 5, C_HALTILL);
    push_exp(f + 4, "p5_halt1", 1, 5, C_HALTILL);
`else
    push_exp(f + 3, "p5_fetch", 1, 5, C_NONE);
    push_exp(f + 5, "p5_hlt",   2, 0, C_NONE);
    push_exp(f + 6, "p5_halt",  2, 0, C_HALT);
`endif
    wait_drain("p5");

    // PC wrap 2047 -> 0
    clear_mem();
    imem[0] = ins(JMP, 2047); imem[2047] = ins(LDI, 1);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 2, "p4_jmp",     1, 2047, C_NONE);
    push_exp(f + 3, "p4_fetch",   2047, 2047, C_NONE);
    push_exp(f + 5, "p4_ldi",     0, 1, C_LDI);
    push_exp(f + 6, "p4_wrapped", 0, 1, C_NONE);
    wait_drain("p4");

    // Reset asserted during LD write-back
    clear_mem();
    imem[0] = ins(LD, 5);
    start_run(1'b0, 1'b0, f);
    push_exp(f + 2, "p6_ld_exec", 1, 5, C_NONE);
    push_exp(f + 3, "p6_rst_wb",  0, 0, C_NONE);
    push_exp(f + 4, "p6_init",    0, 0, C_INIT);
    push_exp(f + 5, "p6_fetch",   0, 0, C_NONE);
    while (cyc < f + 3) tick(1);
    reset_in = 1'b1;
    tick(1);
    reset_in = 1'b0;
    wait_drain("p6");

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
